// File: rtl/anton_neopixel_bus_arbiter.sv
// Two-master round-robin arbiter for the neopixel register bus, with a bounded
// grant lock so one requester can stream a pixel burst without interleaving.
module anton_neopixel_bus_arbiter #(
  parameter int ADDR_BITS    = 14,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_MAX     = 16
) (
  input  logic                 busClk,
  input  logic                 busReset,
  input  logic                 m0_req,
  input  logic                 m1_req,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [7:0]           m0_wdata,
  input  logic [7:0]           m1_wdata,
  input  logic                 m0_write,
  input  logic                 m1_write,
  input  logic                 m0_lock,
  input  logic                 m1_lock,
  output logic                 m0_ack,
  output logic                 m1_ack,
  output logic [7:0]           m0_rdata,
  output logic [7:0]           m1_rdata,
  output logic [ADDR_BITS-1:0] busAddr,
  output logic [7:0]           busDataIn,
  output logic                 busWrite,
  output logic                 busRead,
  input  logic [7:0]           busDataOut,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [2:0] RD_LAST   = 3'(READ_LATENCY);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX);

  state_t         state;
  logic           cur;
  logic           cur_lock;
  logic           last_grant;
  logic           own_valid;
  logic           owner;
  logic [7:0]     lock_cnt;
  logic [2:0]     rd_cnt;

  logic                 win;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [7:0]           sel_wdata;
  logic                 sel_write;
  logic                 sel_lock;
  logic [7:0]           next_cnt;

  always_comb begin
    win = ~last_grant;
    if (own_valid && (owner ? m1_req : m0_req))
      win = owner;
    else if (m0_req != m1_req)
      win = m1_req;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_write = win ? m1_write : m0_write;
    sel_lock  = win ? m1_lock  : m0_lock;
    // Owner is always the current master when set at ack time, so the run just extends.
    next_cnt  = own_valid ? lock_cnt + 8'd1 : 8'd1;
  end

  always_ff @(posedge busClk) begin
    if (busReset) begin
      state      <= IDLE;
      cur        <= 1'b0;
      cur_lock   <= 1'b0;
      last_grant <= 1'b1;
      own_valid  <= 1'b0;
      owner      <= 1'b0;
      lock_cnt   <= '0;
      rd_cnt     <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      busAddr    <= '0;
      busDataIn  <= '0;
      busWrite   <= 1'b0;
      busRead    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            cur        <= win;
            cur_lock   <= sel_lock;
            last_grant <= win;
            busAddr    <= sel_addr;
            busy       <= 1'b1;
            if (own_valid && owner != win) begin
              own_valid <= 1'b0;
              lock_cnt  <= '0;
            end
            if (sel_write) begin
              busDataIn <= sel_wdata;
              busWrite  <= 1'b1;
              m0_ack    <= ~win;
              m1_ack    <= win;
              state     <= WRITE;
            end else begin
              busRead <= 1'b1;
              rd_cnt  <= 3'd1;
              state   <= READ;
            end
          end
        end
        WRITE: begin
          busWrite <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        READ: begin
          if (rd_cnt == RD_LAST) begin
            busRead <= 1'b0;
            if (cur) begin
              m1_rdata <= busDataOut;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= busDataOut;
              m0_ack   <= 1'b1;
            end
            state <= RESP;
          end else begin
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (state == WRITE || state == RESP) begin
        if (cur_lock && next_cnt != LOCK_LAST) begin
          own_valid <= 1'b1;
          owner     <= cur;
          lock_cnt  <= next_cnt;
        end else begin
          own_valid <= 1'b0;
          lock_cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Scoreboard bench for the neopixel bus arbiter: directed beats push expected
// bus/ack entries, a negedge monitor pops and compares them.
module tb_anton_neopixel_bus_arbiter;

  localparam int AB = 14;
  localparam int RL = 2;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, wr, lk;
  logic [AB-1:0] addr [2];
  logic [7:0]    wdata [2];
  logic          m0_ack, m1_ack;
  logic [7:0]    m0_rdata, m1_rdata;
  logic [AB-1:0] busAddr;
  logic [7:0]    busDataIn, busDataOut;
  logic          busWrite, busRead, busy;

  always #5 clk = ~clk;

  anton_neopixel_bus_arbiter #(.ADDR_BITS(AB), .READ_LATENCY(RL), .LOCK_MAX(LM)) dut (
    .busClk(clk), .busReset(rst),
    .m0_req(req[0]), .m1_req(req[1]),
    .m0_addr(addr[0]), .m1_addr(addr[1]),
    .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
    .m0_write(wr[0]), .m1_write(wr[1]),
    .m0_lock(lk[0]), .m1_lock(lk[1]),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .busAddr(busAddr), .busDataIn(busDataIn),
    .busWrite(busWrite), .busRead(busRead),
    .busDataOut(busDataOut), .busy(busy)
  );

  typedef struct {
    int          m;
    bit          w;
    logic [13:0] a;
    logic [7:0]  d;
    bit          l;
  } item_t;

  item_t stim0[$], stim1[$], bus_q[$], ack_q[$];
  int    checks = 0;
  int    fails = 0;
  bit    mon_en = 0, rand_mode = 0, rand_dout = 0, aborted = 0;
  logic [7:0] model [2];
  logic [7:0] cap = '0;
  logic       prev_read = 1'b0;
  int    run = 0;
  int    ack_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int m, input bit w, input logic [13:0] a, input logic [7:0] d, input bit l);
    item_t it;
    it = '{m: m, w: w, a: a, d: d, l: l};
    if (m == 0) stim0.push_back(it);
    else stim1.push_back(it);
  endtask

  task automatic exp_beat(input int m, input bit w, input logic [13:0] a, input logic [7:0] d, input bit with_ack);
    item_t it;
    it = '{m: m, w: w, a: a, d: d, l: 1'b0};
    bus_q.push_back(it);
    if (with_ack) ack_q.push_back(it);
  endtask

  task automatic drive(input int i);
    item_t it;
    int    waitc;
    logic  a;
    waitc = 0;
    forever begin
      @(negedge clk);
      a = (i == 0) ? m0_ack : m1_ack;
      if (a || !req[i]) begin
        waitc = 0;
        if ((i == 0 && stim0.size() > 0) || (i == 1 && stim1.size() > 0)) begin
          if (i == 0) it = stim0.pop_front();
          else it = stim1.pop_front();
          req[i] = 1'b1; wr[i] = it.w; lk[i] = it.l; addr[i] = it.a; wdata[i] = it.d;
        end else begin
          req[i] = 1'b0;
        end
      end else begin
        waitc++;
        if (waitc > 300) begin
          checks++; fails++;
          $display("FAIL m%0d_ack_timeout: got no ack, expected one within 300 cycles", i);
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_dout) busDataOut = 8'($urandom);
  end

  always @(posedge clk) if (rst) begin
    model[0] = '0;
    model[1] = '0;
  end

  always @(negedge clk) if (mon_en) begin
    item_t it;
    logic  a;
    chk("strobe_excl", {31'd0, busWrite & busRead}, 0);
    chk("ack_excl", {31'd0, m0_ack & m1_ack}, 0);
    chk("busy", {31'd0, busy}, {31'd0, busWrite | busRead | m0_ack | m1_ack});
    if (!rand_mode && (busWrite || (busRead && !prev_read))) begin
      if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
      else begin
        it = bus_q.pop_front();
        chk("bus_kind", {31'd0, busWrite}, {31'd0, it.w});
        chk("bus_addr", {18'd0, busAddr}, {18'd0, it.a});
        if (it.w) chk("bus_wdata", {24'd0, busDataIn}, {24'd0, it.d});
      end
    end
    if (busRead) run++;
    else if (run > 0) begin
      if (!aborted) chk("read_len", run, RL);
      run = 0;
    end
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? m0_ack : m1_ack;
      if (a) begin
        chk("ack_align", {31'd0, busWrite | (!busRead & prev_read)}, 1);
        if (rand_mode) begin
          ack_cnt[i]++;
          if (!busWrite) model[i] = cap;
        end else if (ack_q.size() == 0) begin
          chk("ack_unexpected", 1, 0);
        end else begin
          it = ack_q.pop_front();
          chk("ack_master", i, it.m);
          chk("ack_kind", {31'd0, busWrite}, {31'd0, it.w});
          if (!it.w) model[i] = it.d;
        end
      end
    end
    chk("m0_rdata", {24'd0, m0_rdata}, {24'd0, model[0]});
    chk("m1_rdata", {24'd0, m1_rdata}, {24'd0, model[1]});
    if (busRead) cap = busDataOut;
    prev_read = busRead;
  end

  task automatic issue();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    bit done;
    done = 0;
    for (int n = 0; n < lim && !done; n++) begin
      @(negedge clk);
      done = (stim0.size() == 0 && stim1.size() == 0 && req == 2'b00 && !busy);
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL idle_timeout: got busy, expected idle within %0d cycles", lim);
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req = '0; wr = '0; lk = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    busDataOut = '0; model[0] = '0; model[1] = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", {9'd0, busAddr, busDataIn, busWrite}, 0);
    chk("reset_ctl", {11'd0, busRead, busy, m0_ack, m1_ack, m0_rdata, m1_rdata}, 0);
    rst = 1'b0;
    mon_en = 1;

    issue();
    exp_beat(0, 1, 14'h0005, 8'hA5, 1);
    add(0, 1, 14'h0005, 8'hA5, 0);
    wait_idle(50);

    busDataOut = 8'h3C;
    issue();
    exp_beat(1, 0, 14'h1FFF, 8'h3C, 1);
    add(1, 0, 14'h1FFF, 8'h00, 0);
    wait_idle(50);

    issue();
    for (int k = 0; k < 4; k++) begin
      exp_beat(0, 1, 14'h0100 + 14'(k), 8'h10 + 8'(k), 1);
      exp_beat(1, 1, 14'h0200 + 14'(k), 8'h20 + 8'(k), 1);
      add(0, 1, 14'h0100 + 14'(k), 8'h10 + 8'(k), 0);
      add(1, 1, 14'h0200 + 14'(k), 8'h20 + 8'(k), 0);
    end
    wait_idle(100);

    issue();
    for (int k = 0; k < 10; k++) add(1, 1, 14'h0300 + 14'(k), 8'h30 + 8'(k), 1);
    for (int k = 0; k < 4; k++) exp_beat(1, 1, 14'h0300 + 14'(k), 8'h30 + 8'(k), 1);
    exp_beat(0, 1, 14'h0400, 8'h44, 1);
    for (int k = 4; k < 10; k++) exp_beat(1, 1, 14'h0300 + 14'(k), 8'h30 + 8'(k), 1);
    issue();
    add(0, 1, 14'h0400, 8'h44, 0);
    wait_idle(100);

    busDataOut = 8'h77;
    issue();
    exp_beat(0, 0, 14'h0123, 8'h00, 0);
    add(0, 0, 14'h0123, 8'h00, 0);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = busRead;
    end
    chk("abort_read_started", {31'd0, seen}, 1);
    rst = 1'b1; req[0] = 1'b0; aborted = 1;
    @(negedge clk);
    chk("abort_strobes", {28'd0, busRead, busWrite, busy, m0_ack}, 0);
    chk("abort_addr", {18'd0, busAddr}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    aborted = 0;
    issue();
    exp_beat(0, 1, 14'h0050, 8'h5A, 1);
    exp_beat(1, 1, 14'h0060, 8'h6B, 1);
    add(0, 1, 14'h0050, 8'h5A, 0);
    add(1, 1, 14'h0060, 8'h6B, 0);
    wait_idle(50);

    rand_mode = 1; rand_dout = 1;
    issue();
    for (int k = 0; k < 150; k++) begin
      add(0, 1'($urandom), 14'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      add(1, 1'($urandom), 14'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
    end
    wait_idle(5000);
    chk("m0_ack_count", ack_cnt[0], 150);
    chk("m1_ack_count", ack_cnt[1], 150);
    chk("bus_q_left", bus_q.size(), 0);
    chk("ack_q_left", ack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
